// File: rtl/msdap_conv_scheduler.sv
// One-channel MSDAP convolution sequencer: walks Rj/coeff/data memories and shift-accumulates y.
// Build option MSDAP_ZERO_SKIP_EN: zero-length groups finish in LOAD without a SHIFT cycle.
module msdap_conv_scheduler (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  newest_addr,
    output logic [3:0]  rj_addr,
    input  logic [15:0] rj_data,
    output logic [8:0]  coeff_addr,
    input  logic [15:0] coeff_data,
    output logic [7:0]  data_addr,
    input  logic [15:0] data_in,
    output logic [39:0] y_out,
    output logic        y_valid,
    output logic        busy,
    output logic        overrun
);

    // state   | meaning
    // S_IDLE  | waiting for start; address outputs hold
    // S_LOAD  | read tap count of group j
    // S_ACCUM | one tap per cycle into acc
    // S_SHIFT | acc >>>= 1, advance group
    // S_DONE  | y_out valid, y_valid high
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ACCUM,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic signed [41:0] acc;
    logic signed [41:0] ext;
    logic signed [41:0] acc_sum;
    logic signed [41:0] acc_half;
    logic [7:0]         base;
    logic [3:0]         j;
    logic [8:0]         cp;
    logic [8:0]         cnt;
    logic [8:0]         rj_cnt;
    logic [7:0]         tap_addr;
    logic [7:0]         data_addr_q;
    logic               last_group;
    logic               unused_bits;

    assign rj_cnt     = rj_data[8:0];
    assign last_group = (j == 4'd15);
    assign tap_addr   = base - coeff_data[7:0];
    assign ext        = {{10{data_in[15]}}, data_in, 16'h0000};
    assign acc_sum    = coeff_data[8] ? (acc - ext) : (acc + ext);
    assign acc_half   = acc >>> 1;
    assign unused_bits = ^{rj_data[15:9], coeff_data[15:9]};

    assign rj_addr    = j;
    assign coeff_addr = cp;
    // the sample address must be live during ACCUM for the combinational read; otherwise hold it
    assign data_addr  = (state == S_ACCUM) ? tap_addr : data_addr_q;
    assign y_valid    = (state == S_DONE);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_LOAD;
            S_LOAD: begin
`ifdef MSDAP_ZERO_SKIP_EN
                if (rj_cnt != 9'd0)  state_next = S_ACCUM;
                else if (last_group) state_next = S_DONE;
                else                 state_next = S_LOAD;
`else
                if (rj_cnt != 9'd0) state_next = S_ACCUM;
                else                state_next = S_SHIFT;
`endif
            end
            S_ACCUM: if (cnt == 9'd1) state_next = S_SHIFT;
            S_SHIFT: state_next = last_group ? S_DONE : S_LOAD;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            base        <= '0;
            j           <= '0;
            cp          <= '0;
            cnt         <= '0;
            data_addr_q <= '0;
            y_out       <= '0;
            overrun     <= 1'b0;
        end else begin
            overrun <= start && (state != S_IDLE);
            if (abort) begin
                acc <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            base <= newest_addr;
                            acc  <= '0;
                            j    <= '0;
                            cp   <= '0;
                        end
                    end
                    S_LOAD: begin
                        cnt <= rj_cnt;
`ifdef MSDAP_ZERO_SKIP_EN
                        if (rj_cnt == 9'd0) begin
                            acc <= acc_half;
                            if (last_group) y_out <= acc_half[39:0];
                            else            j     <= j + 4'd1;
                        end
`endif
                    end
                    S_ACCUM: begin
                        acc         <= acc_sum;
                        cp          <= cp + 9'd1;
                        cnt         <= cnt - 9'd1;
                        data_addr_q <= tap_addr;
                    end
                    S_SHIFT: begin
                        acc <= acc_half;
                        // y_out is loaded on entry to DONE so it is valid alongside y_valid
                        if (last_group) y_out <= acc_half[39:0];
                        else            j     <= j + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_msdap_conv_scheduler.sv
// Self-checking bench for msdap_conv_scheduler: directed cases plus random memories vs a tap-sum model.
module tb_msdap_conv_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  newest_addr = 8'h00;
    logic [3:0]  rj_addr;
    logic [15:0] rj_data;
    logic [8:0]  coeff_addr;
    logic [15:0] coeff_data;
    logic [7:0]  data_addr;
    logic [15:0] data_in;
    logic [39:0] y_out;
    logic        y_valid;
    logic        busy;
    logic        overrun;

    logic [15:0] rj_mem [16];
    logic [15:0] coeff_mem [512];
    logic [15:0] data_mem [256];

    int n_checks = 0;
    int n_errors = 0;
    int valid_count = 0;
    int ovr_count = 0;

    always #5 clk = ~clk;

    assign rj_data    = rj_mem[rj_addr];
    assign coeff_data = coeff_mem[coeff_addr];
    assign data_in    = data_mem[data_addr];

    msdap_conv_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .newest_addr (newest_addr),
        .rj_addr     (rj_addr),
        .rj_data     (rj_data),
        .coeff_addr  (coeff_addr),
        .coeff_data  (coeff_data),
        .data_addr   (data_addr),
        .data_in     (data_in),
        .y_out       (y_out),
        .y_valid     (y_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always @(negedge clk) begin
        if (y_valid === 1'b1) valid_count = valid_count + 1;
        if (overrun === 1'b1) ovr_count = ovr_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++)  rj_mem[i] = 16'h0000;
        for (int i = 0; i < 512; i++) coeff_mem[i] = 16'h0000;
        for (int i = 0; i < 256; i++) data_mem[i] = 16'h0000;
    endtask

    function automatic longint wrap42(input longint v);
        return (v <<< 22) >>> 22;
    endfunction

    // y = (...((u0>>1)+u1)>>1 ... + u15)>>1 with samples scaled by 2^16 in a 42-bit accumulator
    function automatic logic [39:0] model(input logic [7:0] base, output int s, output int z);
        longint acc;
        int cp;
        acc = 0;
        cp = 0;
        s = 0;
        z = 0;
        for (int g = 0; g < 16; g++) begin
            int n;
            n = int'(rj_mem[g][8:0]);
            s += n;
            if (n == 0) z++;
            for (int t = 0; t < n; t++) begin
                logic [15:0] c;
                logic [7:0]  a;
                longint      x;
                c = coeff_mem[cp];
                a = base - c[7:0];
                x = longint'($signed(data_mem[a])) * 65536;
                acc = c[8] ? acc - x : acc + x;
                cp = (cp + 1) % 512;
            end
            acc = wrap42(acc) >>> 1;
        end
        return acc[39:0];
    endfunction

    task automatic run_conv(input logic [7:0] base, input string tag, output logic [39:0] y_exp);
        int s, z, exp_lat, n;
        y_exp = model(base, s, z);
`ifdef MSDAP_ZERO_SKIP_EN
        exp_lat = 32 + s - z;
`else
        exp_lat = 32 + s;
`endif
        newest_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
        newest_addr = 8'($urandom);
        check({tag, " busy_after_start"}, 64'(busy), 64'd1);
        n = 0;
        while (y_valid !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(exp_lat));
        check({tag, " y_out"}, 64'(y_out), 64'(y_exp));
        tick();
        check({tag, " busy_low_after_done"}, 64'(busy), 64'd0);
        check({tag, " y_valid_one_cycle"}, 64'(y_valid), 64'd0);
    endtask

    initial begin
        logic [39:0] y_exp;
        logic [39:0] prev_y;
        int v0, o0;

        clear_mem();
        #12;
        check("reset y_out", 64'(y_out), 64'd0);
        check("reset y_valid", 64'(y_valid), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset overrun", 64'(overrun), 64'd0);
        check("reset rj_addr", 64'(rj_addr), 64'd0);
        check("reset coeff_addr", 64'(coeff_addr), 64'd0);
        check("reset data_addr", 64'(data_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // single tap in the last group
        rj_mem[15] = 16'h0001;
        data_mem[8'h10] = 16'h0001;
        run_conv(8'h10, "last_group", y_exp);
        check("last_group const", 64'(y_out), 64'h00_0000_8000);

        // single tap in the first group, 16 shifts
        clear_mem();
        rj_mem[0] = 16'h0001;
        data_mem[8'h10] = 16'h0001;
        run_conv(8'h10, "first_group", y_exp);
        check("first_group const", 64'(y_out), 64'h00_0000_0001);

        // subtracting tap
        clear_mem();
        rj_mem[15] = 16'h0001;
        coeff_mem[0] = 16'h0100;
        data_mem[8'h10] = 16'h0001;
        run_conv(8'h10, "negative", y_exp);
        check("negative const", 64'(y_out), 64'hFF_FFFF_8000);

        // data address wraps below zero
        clear_mem();
        rj_mem[15] = 16'h0001;
        coeff_mem[0] = 16'h0003;
        data_mem[8'hFF] = 16'h0002;
        run_conv(8'h02, "addr_wrap", y_exp);
        check("addr_wrap const", 64'(y_out), 64'h00_0001_0000);
        check("addr_wrap data_addr", 64'(data_addr), 64'hFF);

        // re-start while busy, then abort
        clear_mem();
        rj_mem[15] = 16'h0001;
        data_mem[8'h10] = 16'h0001;
        prev_y = y_out;
        v0 = valid_count;
        o0 = ovr_count;
        newest_addr = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("overrun pulse", 64'(overrun), 64'd1);
        tick();
        check("overrun single", 64'(overrun), 64'd0);
        repeat (3) tick();
        check("busy before abort", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("busy after abort", 64'(busy), 64'd0);
        repeat (40) tick();
        check("abort overrun count", 64'(ovr_count - o0), 64'd1);
        check("abort no y_valid", 64'(valid_count - v0), 64'd0);
        check("abort y_out held", 64'(y_out), 64'(prev_y));
        run_conv(8'h10, "after_abort", y_exp);

        // reset in the middle of ACCUM
        clear_mem();
        rj_mem[0] = 16'd20;
        for (int i = 0; i < 20; i++) coeff_mem[i] = 16'(i);
        for (int i = 0; i < 256; i++) data_mem[i] = 16'(i * 3 + 1);
        newest_addr = 8'h40;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst y_out", 64'(y_out), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst coeff_addr", 64'(coeff_addr), 64'd0);
        check("midrst rj_addr", 64'(rj_addr), 64'd0);
        check("midrst data_addr", 64'(data_addr), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_conv(8'h40, "after_reset", y_exp);

        // random memories, ignored upper bits randomized too
        for (int it = 0; it < 8; it++) begin
            logic [15:0] r;
            clear_mem();
            for (int g = 0; g < 16; g++) begin
                r = 16'($urandom) & 16'hFE00;
                if ($urandom_range(0, 2) != 0) r = r | 16'($urandom_range(1, 6));
                if (it == 7) r = (r & 16'hFE00) | 16'd40;
                rj_mem[g] = r;
            end
            for (int i = 0; i < 512; i++) coeff_mem[i] = 16'($urandom);
            for (int i = 0; i < 256; i++) data_mem[i] = 16'($urandom);
            run_conv(8'($urandom), $sformatf("random%0d", it), y_exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
